// File: rtl/tcs_pkg.sv
// Shared types and constants for the timed command scheduler.
package tcs_pkg;

  localparam int CLK_PER_US = 48;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FETCH,
    ISSUE
  } state_t;

endpackage

// File: rtl/tcs_ram_sdp.sv
// Simple dual-port command RAM, one write port and one registered read port.
module tcs_ram_sdp #(
  parameter  int DEPTH = 256,
  parameter  int W     = 338,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; occupancy lives in the valid bitmap.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/timed_cmd_sched.sv
// Timed command scheduler: stores time-stamped commands and issues the earliest due one.
// Optional build macro STALE_PURGE_EN frees stale entries during scans and adds stale_cnt.
module timed_cmd_sched
  import tcs_pkg::*;
#(
  parameter  int DEPTH       = 256,
  parameter  int TW          = 64,
  parameter  int PW          = 274,
  parameter  int TIME_REZERV = 8 * CLK_PER_US,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic [TW-1:0] cur_time,
  input  logic          time_update,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [TW-1:0] wr_time,
  input  logic [PW-1:0] wr_payload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [TW-1:0] out_time,
  output logic [PW-1:0] out_payload,
  output logic [AW:0]   count,
  output logic          full,
`ifdef STALE_PURGE_EN
  output logic [15:0]   stale_cnt,
`endif
  output logic          scan_busy
);

  typedef struct packed {
    logic [TW-1:0] tstamp;
    logic [PW-1:0] payload;
  } entry_t;

  state_t          state;
  logic [DEPTH-1:0] valid;
  logic [TW-1:0]   t_now;
  logic [TW:0]     t_lim;
  logic            cand_valid;
  logic [TW-1:0]   cand_time;
  logic [AW-1:0]   cand_slot;
  logic            rescan_pend;
  logic [AW:0]     scan_cnt;
  logic            best_valid, nxt_best_valid;
  logic [TW-1:0]   best_time, nxt_best_time;
  logic [AW-1:0]   best_slot, nxt_best_slot;
  logic [AW-1:0]   free_slot, rd_addr, cmp_slot;
  logic            due_start, wr_fire, cmp_active, cmp_live, cmp_future, take;
  entry_t          wr_entry, rd_entry;

  // Window limit carries one extra bit so t_now near the top of the range never wraps.
  assign t_lim     = {1'b0, t_now} + (TW+1)'(TIME_REZERV);
  assign due_start = cand_valid && ({1'b0, cand_time} <= t_lim);
  assign full      = (count == (AW+1)'(DEPTH));
  assign wr_ready  = (state == IDLE) && !full && !due_start;
  assign wr_fire   = wr_valid && wr_ready;
  assign scan_busy = (state == SCAN) || (state == FETCH);
  assign wr_entry  = '{tstamp: wr_time, payload: wr_payload};

  // Outside SCAN the candidate slot is read continuously so FETCH finds it ready.
  assign rd_addr    = (state == SCAN) ? scan_cnt[AW-1:0] : cand_slot;
  assign cmp_slot   = AW'(scan_cnt - (AW+1)'(1));
  assign cmp_active = (state == SCAN) && (scan_cnt != '0);
  assign cmp_live   = cmp_active && valid[cmp_slot];
  assign cmp_future = rd_entry.tstamp > t_now;
  assign take       = cmp_live && cmp_future && (!best_valid || rd_entry.tstamp < best_time);

  tcs_ram_sdp #(.DEPTH(DEPTH), .W(TW + PW)) u_ram (
    .CLK     (CLK),
    .wr_en   (wr_fire),
    .wr_addr (free_slot),
    .wr_data (wr_entry),
    .rd_addr (rd_addr),
    .rd_data (rd_entry)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    free_slot = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) free_slot = AW'(i);
    end
  end

  always_comb begin
    nxt_best_valid = best_valid;
    nxt_best_time  = best_time;
    nxt_best_slot  = best_slot;
    if (take) begin
      nxt_best_valid = 1'b1;
      nxt_best_time  = rd_entry.tstamp;
      nxt_best_slot  = cmp_slot;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      valid       <= '0;
      count       <= '0;
      t_now       <= '0;
      cand_valid  <= 1'b0;
      cand_time   <= '0;
      cand_slot   <= '0;
      rescan_pend <= 1'b0;
      scan_cnt    <= '0;
      best_valid  <= 1'b0;
      best_time   <= '0;
      best_slot   <= '0;
      out_valid   <= 1'b0;
      out_time    <= '0;
      out_payload <= '0;
`ifdef STALE_PURGE_EN
      stale_cnt   <= '0;
`endif
    end else begin
      t_now <= cur_time;
      case (state)
        IDLE: begin
          if (due_start) begin
            state <= FETCH;
          end else begin
            if (wr_fire) begin
              valid[free_slot] <= 1'b1;
              count            <= count + (AW+1)'(1);
              if (wr_time > t_now && (!cand_valid || wr_time < cand_time)) begin
                cand_valid <= 1'b1;
                cand_time  <= wr_time;
                cand_slot  <= free_slot;
              end
            end
            if (time_update || rescan_pend) begin
              state       <= SCAN;
              rescan_pend <= 1'b0;
              scan_cnt    <= '0;
              best_valid  <= 1'b0;
            end
          end
        end
        SCAN: begin
          if (time_update) rescan_pend <= 1'b1;
          best_valid <= nxt_best_valid;
          best_time  <= nxt_best_time;
          best_slot  <= nxt_best_slot;
`ifdef STALE_PURGE_EN
          if (cmp_live && !cmp_future) begin
            valid[cmp_slot] <= 1'b0;
            count           <= count - (AW+1)'(1);
            if (stale_cnt != 16'hFFFF) stale_cnt <= stale_cnt + 16'd1;
          end
`endif
          if (scan_cnt == (AW+1)'(DEPTH)) begin
            cand_valid <= nxt_best_valid;
            cand_time  <= nxt_best_time;
            cand_slot  <= nxt_best_slot;
            state      <= IDLE;
          end else begin
            scan_cnt <= scan_cnt + (AW+1)'(1);
          end
        end
        FETCH: begin
          out_time    <= rd_entry.tstamp;
          out_payload <= rd_entry.payload;
          out_valid   <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          if (out_ready) begin
            out_valid        <= 1'b0;
            valid[cand_slot] <= 1'b0;
            count            <= count - (AW+1)'(1);
            cand_valid       <= 1'b0;
            state            <= SCAN;
            scan_cnt         <= '0;
            best_valid       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timed_cmd_sched.sv
// Directed self-checking bench for timed_cmd_sched (default parameters).
module tb_timed_cmd_sched;

  localparam int DEPTH = 256;
  localparam int TW    = 64;
  localparam int PW    = 274;
  localparam int AW    = $clog2(DEPTH);

  logic          CLK         = 1'b0;
  logic          rst_n       = 1'b0;
  logic [TW-1:0] cur_time    = '0;
  logic          time_update = 1'b0;
  logic          wr_valid    = 1'b0;
  logic          wr_ready;
  logic [TW-1:0] wr_time     = '0;
  logic [PW-1:0] wr_payload  = '0;
  logic          out_valid;
  logic          out_ready   = 1'b0;
  logic [TW-1:0] out_time;
  logic [PW-1:0] out_payload;
  logic [AW:0]   count;
  logic          full;
  logic          scan_busy;
`ifdef STALE_PURGE_EN
  logic [15:0]   stale_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  timed_cmd_sched dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .cur_time    (cur_time),
    .time_update (time_update),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_time     (wr_time),
    .wr_payload  (wr_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_time    (out_time),
    .out_payload (out_payload),
    .count       (count),
    .full        (full),
`ifdef STALE_PURGE_EN
    .stale_cnt   (stale_cnt),
`endif
    .scan_busy   (scan_busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [PW-1:0] pl(input logic [TW-1:0] t);
    return {18'h25A5A, ~t, t, t + 64'd1, t ^ 64'hDEAD_BEEF_0BAD_F00D};
  endfunction

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [TW-1:0] t);
    int n = 0;
    wr_valid   = 1'b1;
    wr_time    = t;
    wr_payload = pl(t);
    while (!wr_ready && n < 2000) begin
      tick();
      n++;
    end
    check("wr_accept", PW'(wr_ready), PW'(1'b1));
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n, input int bound);
    n = 0;
    while (!out_valid && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic scan_len(output int n);
    n = 0;
    while (scan_busy && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic issue_one(input logic [TW-1:0] exp_t, input string tag);
    int n;
    wait_valid(n, 20);
    check({tag, "_valid"}, PW'(out_valid), PW'(1'b1));
    check({tag, "_time"}, PW'(out_time), PW'(exp_t));
    check({tag, "_payload"}, out_payload, pl(exp_t));
    tick();
    check({tag, "_released"}, PW'(out_valid), PW'(1'b0));
    scan_len(n);
    check({tag, "_scan_len"}, PW'(n), PW'(DEPTH + 1));
  endtask

  initial begin
    int n;
    logic seen;
    logic stable;
    logic [PW-1:0] cap_p;

    // Reset state
    cur_time = 64'd500;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_count", PW'(count), PW'(0));
    check("rst_full", PW'(full), PW'(0));
    check("rst_out_valid", PW'(out_valid), PW'(0));
    check("rst_scan_busy", PW'(scan_busy), PW'(0));
    check("rst_out_time", PW'(out_time), PW'(0));
    check("rst_out_payload", out_payload, PW'(0));
    check("rst_wr_ready", PW'(wr_ready), PW'(1));
`ifdef STALE_PURGE_EN
    check("rst_stale_cnt", PW'(stale_cnt), PW'(0));
`endif

    // Single command: due once t_now + 384 reaches 1300
    out_ready = 1'b1;
    wr(64'd1300);
    check("t1_count1", PW'(count), PW'(1));
    cur_time = 64'd915;
    repeat (3) tick();
    check("t1_not_due", PW'(out_valid), PW'(0));
    cur_time = 64'd916;
    wait_valid(n, 10);
    check("t1_latency_le3", PW'(n <= 3), PW'(1));
    check("t1_valid", PW'(out_valid), PW'(1));
    check("t1_time", PW'(out_time), PW'(1300));
    check("t1_payload", out_payload, pl(64'd1300));
    tick();
    check("t1_released", PW'(out_valid), PW'(0));
    check("t1_count0", PW'(count), PW'(0));
    check("t1_scan_busy", PW'(scan_busy), PW'(1));
    scan_len(n);
    check("t1_scan_len", PW'(n), PW'(DEPTH + 1));
    check("t1_empty_no_issue", PW'(out_valid), PW'(0));

    // Out-of-order writes issue in time order
    cur_time = 64'd1000;
    tick();
    wr(64'd5000);
    wr(64'd3000);
    wr(64'd4000);
    check("t2_count3", PW'(count), PW'(3));
    cur_time = 64'd2800;
    issue_one(64'd3000, "t2_a");
    cur_time = 64'd3700;
    issue_one(64'd4000, "t2_b");
    cur_time = 64'd4700;
    issue_one(64'd5000, "t2_c");
    check("t2_count0", PW'(count), PW'(0));

    // Fill every slot, then a blocked write lands once slot 0 frees
    cur_time = 64'd1000;
    tick();
    for (int i = 0; i < DEPTH; i++) wr(64'd10000 + 64'(i));
    check("t3_full", PW'(full), PW'(1));
    check("t3_count", PW'(count), PW'(DEPTH));
    check("t3_wr_ready_low", PW'(wr_ready), PW'(0));
    wr_valid   = 1'b1;
    wr_time    = 64'd9500;
    wr_payload = pl(64'd9500);
    repeat (10) tick();
    check("t3_blocked", PW'(wr_ready), PW'(0));
    check("t3_count_held", PW'(count), PW'(DEPTH));
    cur_time = 64'd9700;
    wait_valid(n, 20);
    check("t3_first_time", PW'(out_time), PW'(10000));
    cur_time = 64'd9000;
    tick();
    check("t3_count_dec", PW'(count), PW'(DEPTH - 1));
    check("t3_not_full", PW'(full), PW'(0));
    n = 0;
    while (!wr_ready && n < 1000) begin
      tick();
      n++;
    end
    check("t3_w257_ready", PW'(wr_ready), PW'(1));
    tick();
    wr_valid = 1'b0;
    check("t3_refull_count", PW'(count), PW'(DEPTH));
    check("t3_refull", PW'(full), PW'(1));
    cur_time = 64'd9200;
    issue_one(64'd9500, "t3_w257");
    cur_time = 64'd9617;
    issue_one(64'd10001, "t3_slot1");
    check("t3_count_end", PW'(count), PW'(DEPTH - 2));

    // Back-pressure: outputs held while out_ready is low
    out_ready = 1'b0;
    cur_time  = 64'd9620;
    wait_valid(n, 20);
    check("t4_valid", PW'(out_valid), PW'(1));
    check("t4_time", PW'(out_time), PW'(10002));
    cap_p  = out_payload;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 25) cur_time = 64'd10050;
      tick();
      if (out_valid !== 1'b1 || out_time !== 64'd10002 || out_payload !== cap_p ||
          count !== 9'd254) stable = 1'b0;
    end
    check("t4_stable", PW'(stable), PW'(1));
    check("t4_payload", out_payload, pl(64'd10002));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_hs_valid", PW'(out_valid), PW'(0));
    check("t4_hs_count", PW'(count), PW'(253));
    check("t4_hs_scan", PW'(scan_busy), PW'(1));

    // Stale entries skipped; then reset during ISSUE
    wait_valid(n, 400);
    check("t6_next_time", PW'(out_time), PW'(10051));
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", PW'(out_valid), PW'(0));
    check("t6_rst_count", PW'(count), PW'(0));
    check("t6_rst_full", PW'(full), PW'(0));
    check("t6_rst_scan", PW'(scan_busy), PW'(0));
    cur_time  = 64'd1000;
    out_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("t6_no_issue", PW'(seen), PW'(0));
    check("t6_count", PW'(count), PW'(0));

    // time_update jump makes the candidate stale
    wr(64'd2000);
    check("t5_count1", PW'(count), PW'(1));
    repeat (5) tick();
    check("t5_not_due", PW'(out_valid), PW'(0));
    time_update = 1'b1;
    cur_time    = 64'd2500;
    tick();
    time_update = 1'b0;
    check("t5_scan", PW'(scan_busy), PW'(1));
    seen = 1'b0;
    n    = 0;
    while (scan_busy && n < 2000) begin
      tick();
      n++;
      if (out_valid) seen = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("t5_no_issue", PW'(seen), PW'(0));
`ifdef STALE_PURGE_EN
    check("t5_count", PW'(count), PW'(0));
    check("t5_stale_cnt", PW'(stale_cnt), PW'(1));
`else
    check("t5_count", PW'(count), PW'(1));
`endif
    wr(64'd2400);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("t5_stale_write_no_issue", PW'(seen), PW'(0));
`ifdef STALE_PURGE_EN
    check("t5_stale_write_count", PW'(count), PW'(1));
`else
    check("t5_stale_write_count", PW'(count), PW'(2));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
